// File: rtl/sb_config_loader_if.sv
// Serial bitstream handshake between a bitstream source and sb_config_loader.
// A bit moves on any rising edge where bit_valid and bit_ready are both high.
interface sb_config_loader_if;
    logic bit_in;
    logic bit_valid;
    logic frame_start;
    logic bit_ready;

    modport master (output bit_in, output bit_valid, output frame_start, input bit_ready);
    modport slave  (input bit_in, input bit_valid, input frame_start, output bit_ready);
endinterface

// File: rtl/sb_config_loader.sv
// Deserialises address/data/parity frames and broadcasts each good word with a
// one-cycle one-hot write strobe to the switch-box / PE configuration registers.
//
// state  | meaning
// IDLE   | waiting for a bit flagged frame_start
// ADDR   | shifting in the remaining address bits
// DATA   | shifting config word into the staging register
// PARITY | checking even parity and address range
// WRITE  | one cycle: staging -> config_data, strobe config_en
module sb_config_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_TARGETS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sb_config_loader_if.slave      bs,
    output logic [DATA_WIDTH-1:0]  config_data,
    output logic [NUM_TARGETS-1:0] config_en,
    output logic                   busy,
    output logic                   err,
    input  logic                   err_clr,
    output logic [15:0]            frame_count
);

    localparam int MAXW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, PARITY, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  stage_q, stage_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic [DATA_WIDTH-1:0]  config_data_q, config_data_d;
    logic [NUM_TARGETS-1:0] config_en_q, config_en_d;
    logic                   err_q, err_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   bit_ready_q, bit_ready_d;
    logic                   busy_q, busy_d;
    logic                   xfer;
    logic                   start;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        stage_d       = stage_q;
        cnt_d         = cnt_q;
        par_d         = par_q;
        config_data_d = config_data_q;
        config_en_d   = '0;
        err_d         = err_q;
        frame_count_d = frame_count_q;
        start         = 1'b0;
        xfer          = bs.bit_valid & bit_ready_q;

        if (err_clr) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer && bs.frame_start) start = 1'b1;
            end
            ADDR, DATA, PARITY: begin
                if (xfer && bs.frame_start) begin
                    // abandon the frame; this bit is the next frame's address MSB
                    start = 1'b1;
                    err_d = 1'b1;
                end else if (xfer) begin
                    if (state_q == ADDR) begin
                        addr_d = ADDR_WIDTH'({addr_q, bs.bit_in});
                        par_d  = par_q ^ bs.bit_in;
                        if (cnt_q == '0) begin
                            state_d = DATA;
                            cnt_d   = CW'(DATA_WIDTH - 1);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end else if (state_q == DATA) begin
                        stage_d = DATA_WIDTH'({stage_q, bs.bit_in});
                        par_d   = par_q ^ bs.bit_in;
                        if (cnt_q == '0) state_d = PARITY;
                        else             cnt_d   = cnt_q - CW'(1);
                    end else begin
                        if (!(par_q ^ bs.bit_in) && (32'(addr_q) < 32'(NUM_TARGETS))) begin
                            state_d = WRITE;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                config_data_d = stage_q;
                for (int i = 0; i < NUM_TARGETS; i++) config_en_d[i] = (32'(addr_q) == 32'(i));
                frame_count_d = frame_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            addr_d = ADDR_WIDTH'(bs.bit_in);
            par_d  = bs.bit_in;
            if (ADDR_WIDTH == 1) begin
                state_d = DATA;
                cnt_d   = CW'(DATA_WIDTH - 1);
            end else begin
                state_d = ADDR;
                cnt_d   = CW'(ADDR_WIDTH - 2);
            end
        end

        bit_ready_d = (state_d != WRITE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            stage_q       <= '0;
            cnt_q         <= '0;
            par_q         <= 1'b0;
            config_data_q <= '0;
            config_en_q   <= '0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
            bit_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            stage_q       <= stage_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            config_data_q <= config_data_d;
            config_en_q   <= config_en_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
            bit_ready_q   <= bit_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign bs.bit_ready  = bit_ready_q;
    assign config_data   = config_data_q;
    assign config_en     = config_en_q;
    assign err           = err_q;
    assign frame_count   = frame_count_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed-frame bench: the sequence queues the expected write strobes, and a
// monitor pops and compares whenever either loader pulses config_en.
module tb_sb_config_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr0  = 1'b0;
    logic clr1  = 1'b0;

    always #5 clk = ~clk;

    sb_config_loader_if bs0 ();
    sb_config_loader_if bs1 ();

    logic [31:0] cd0, cd1;
    logic [15:0] en0;
    logic [7:0]  en1;
    logic        busy0, busy1, err0, err1;
    logic [15:0] fc0, fc1;

    sb_config_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_TARGETS(16)) dut0 (
        .clk(clk), .reset(rst_n), .bs(bs0), .config_data(cd0), .config_en(en0),
        .busy(busy0), .err(err0), .err_clr(clr0), .frame_count(fc0));

    sb_config_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_TARGETS(8)) dut1 (
        .clk(clk), .reset(rst_n), .bs(bs1), .config_data(cd1), .config_en(en1),
        .busy(busy1), .err(err1), .err_clr(clr1), .frame_count(fc1));

    typedef struct {
        logic [15:0] en;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int vectors     = 0;
    int miscompares = 0;
    int rdy_low     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!bs0.bit_ready) rdy_low++;
            if (en0 != 16'h0) begin
                if (q0.size() == 0) chk("unexpected_pulse0", {16'h0, en0}, 32'h0);
                else begin
                    e0 = q0.pop_front();
                    chk("pulse0_en", {16'h0, en0}, {16'h0, e0.en});
                    chk("pulse0_data", cd0, e0.data);
                    chk("pulse0_count", {16'h0, fc0}, {16'h0, e0.cnt});
                end
            end
            if (en1 != 8'h0) begin
                if (q1.size() == 0) chk("unexpected_pulse1", {24'h0, en1}, 32'h0);
                else begin
                    e1 = q1.pop_front();
                    chk("pulse1_en", {24'h0, en1}, {16'h0, e1.en});
                    chk("pulse1_data", cd1, e1.data);
                    chk("pulse1_count", {16'h0, fc1}, {16'h0, e1.cnt});
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic b, input logic fs, input logic c);
        if (sel == 0) begin
            bs0.bit_valid = v; bs0.bit_in = b; bs0.frame_start = fs; clr0 = c;
        end else begin
            bs1.bit_valid = v; bs1.bit_in = b; bs1.frame_start = fs; clr1 = c;
        end
    endtask

    task automatic send_bit(input int sel, input logic b, input logic fs, input bit gap, input logic c);
        int tries;
        if (gap && $urandom_range(1, 0) == 1) begin
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(sel, 1'b1, b, fs, c);
        tries = 0;
        while (!((sel == 0) ? bs0.bit_ready : bs1.bit_ready) && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) chk("ready_timeout", 32'(tries), 32'd0);
        @(posedge clk);
    endtask

    // abort_at >= 0 stops after that many data bits, leaving the frame unfinished
    task automatic send_frame(input int sel, input logic [3:0] addr, input logic [31:0] data,
                              input logic flip, input bit gap, input int abort_at, input logic clr_par);
        logic p;
        for (int i = 3; i >= 0; i--) send_bit(sel, addr[i], (i == 3), gap, 1'b0);
        for (int j = 31; j >= 0; j--) begin
            if (abort_at >= 0 && (31 - j) == abort_at) return;
            send_bit(sel, data[j], 1'b0, gap, 1'b0);
        end
        p = (^addr) ^ (^data) ^ flip;
        send_bit(sel, p, 1'b0, gap, clr_par);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr0();
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
    endtask

    int r;

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);

        #3 rst_n = 1'b0;
        #1;
        chk("rst_config_data", cd0, 32'h0);
        chk("rst_config_en", {16'h0, en0}, 32'h0);
        chk("rst_err", {31'h0, err0}, 32'h0);
        chk("rst_frame_count", {16'h0, fc0}, 32'h0);
        chk("rst_bit_ready", {31'h0, bs0.bit_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy0}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'h0, bs0.bit_ready}, 32'h1);

        q0.push_back('{16'h0008, 32'hA5A5_0F0F, 16'd1});
        send_frame(0, 4'h3, 32'hA5A5_0F0F, 1'b0, 1'b0, -1, 1'b0);
        idle(4);
        chk("good_err", {31'h0, err0}, 32'h0);
        chk("good_count", {16'h0, fc0}, 32'd1);
        chk("good_busy_idle", {31'h0, busy0}, 32'h0);

        send_frame(0, 4'h3, 32'hA5A5_0F0F, 1'b1, 1'b0, -1, 1'b0);
        idle(4);
        chk("badpar_err", {31'h0, err0}, 32'h1);
        chk("badpar_data_held", cd0, 32'hA5A5_0F0F);
        chk("badpar_count", {16'h0, fc0}, 32'd1);
        pulse_clr0();
        chk("err_clr", {31'h0, err0}, 32'h0);

        send_frame(0, 4'h3, 32'hA5A5_0F0F, 1'b1, 1'b0, -1, 1'b1);
        idle(2);
        chk("error_beats_clr", {31'h0, err0}, 32'h1);
        pulse_clr0();

        send_frame(1, 4'hF, 32'h1234_5678, 1'b0, 1'b0, -1, 1'b0);
        idle(4);
        chk("range_err", {31'h0, err1}, 32'h1);
        chk("range_count", {16'h0, fc1}, 32'd0);
        q1.push_back('{16'h0004, 32'h0BAD_F00D, 16'd1});
        send_frame(1, 4'h2, 32'h0BAD_F00D, 1'b0, 1'b0, -1, 1'b0);
        idle(4);
        chk("narrow_count", {16'h0, fc1}, 32'd1);

        q0.push_back('{16'h0002, 32'h0000_0001, 16'd2});
        send_frame(0, 4'h1, 32'hFFFF_0000, 1'b0, 1'b0, 10, 1'b0);
        send_frame(0, 4'h1, 32'h0000_0001, 1'b0, 1'b0, -1, 1'b0);
        idle(4);
        chk("abort_err", {31'h0, err0}, 32'h1);
        chk("abort_data", cd0, 32'h0000_0001);
        chk("abort_count", {16'h0, fc0}, 32'd2);
        pulse_clr0();

        r = rdy_low;
        q0.push_back('{16'h0001, 32'hDEAD_BEEF, 16'd3});
        send_frame(0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, -1, 1'b0);
        idle(4);
        chk("gap_ready_low_cycles", 32'(rdy_low - r), 32'd1);
        chk("gap_err", {31'h0, err0}, 32'h0);
        chk("gap_count", {16'h0, fc0}, 32'd3);

        send_frame(0, 4'h5, 32'hCAFE_F00D, 1'b0, 1'b0, 20, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midrst_count", {16'h0, fc0}, 32'd0);
        chk("midrst_busy", {31'h0, busy0}, 32'h0);
        chk("midrst_data", cd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        q0.push_back('{16'h0040, 32'h1234_5678, 16'd1});
        send_frame(0, 4'h6, 32'h1234_5678, 1'b0, 1'b0, -1, 1'b0);
        idle(4);
        chk("postrst_count", {16'h0, fc0}, 32'd1);
        chk("postrst_err", {31'h0, err0}, 32'h0);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
